mem_arbiter: RTL and testbench

//  Sits directly downstream of the caches block. Takes the separate instruction and data

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Serialises instruction and data cache requests onto one variable-latency RAM port.
// Optional anti-starvation guard for instruction fetches: define STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [2:0] {IDLE, DBUSY, IBUSY, DDONE, IDONE} state_t;

    state_t            state_q, state_d;
    logic              iwait_q, iwait_d;
    logic              dwait_q, dwait_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;
    logic              ramREN_q, ramREN_d;
    logic              ramWEN_q, ramWEN_d;
    logic [WORD_W-1:0] ramaddr_q, ramaddr_d;
    logic [WORD_W-1:0] ramstore_q, ramstore_d;

    logic dreq;
    logic instr_first;
    logic grant_d, grant_i;

    assign dreq    = dREN | dWEN;
    assign grant_d = (state_q == IDLE) && (state_d == DBUSY);
    assign grant_i = (state_q == IDLE) && (state_d == IBUSY);

`ifdef STARVE_GUARD_EN
    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign instr_first = iREN && (starve_q == CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting fetch; any fetch grant clears it.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && iREN && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign instr_first = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            iwait_q    <= 1'b1;
            dwait_q    <= 1'b1;
            iload_q    <= '0;
            dload_q    <= '0;
            ramREN_q   <= 1'b0;
            ramWEN_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            state_q    <= state_d;
            iwait_q    <= iwait_d;
            dwait_q    <= dwait_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ramREN_q   <= ramREN_d;
            ramWEN_q   <= ramWEN_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (instr_first) begin
                    state_d = IBUSY;
                end else if (dreq) begin
                    state_d = DBUSY;
                end else if (iREN) begin
                    state_d = IBUSY;
                end
            end
            DBUSY:        if (ramready) state_d = DDONE;
            IBUSY:        if (ramready) state_d = IDONE;
            DDONE, IDONE: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    // Outputs are registered, so their next values are derived from the next state.
    always_comb begin
        iwait_d    = (state_d != IDONE);
        dwait_d    = (state_d != DDONE);
        iload_d    = iload_q;
        dload_d    = dload_q;
        ramREN_d   = ramREN_q;
        ramWEN_d   = ramWEN_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;

        if (grant_d) begin
            ramaddr_d  = daddr;
            ramstore_d = dstore;
            ramWEN_d   = dWEN;
            ramREN_d   = ~dWEN;
        end else if (grant_i) begin
            ramaddr_d = iaddr;
            ramREN_d  = 1'b1;
            ramWEN_d  = 1'b0;
        end

        if (ramready && ((state_q == DBUSY) || (state_q == IBUSY))) begin
            ramREN_d = 1'b0;
            ramWEN_d = 1'b0;
            if (state_q == IBUSY) begin
                iload_d = ramload;
            end else if (ramREN_q) begin
                dload_d = ramload;
            end
        end
    end

    assign iwait    = iwait_q;
    assign dwait    = dwait_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ramREN_q;
    assign ramWEN   = ramWEN_q;
    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a cycle-count model.
module tb_mem_arbiter;

    localparam int unsigned W     = 32;
    localparam int unsigned LIMIT = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST, iREN, dREN, dWEN, ramready;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [W-1:0] iload, dload, ramaddr, ramstore;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_iload, exp_dload;
    logic [W-1:0] mem [16];

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
        iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33; ramready = 1'b0; ramload = '0;
        next_cycle();
        next_cycle();
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_ctrl: got iwait,dwait,ren,wen=%b want 1100", {iwait, dwait, ramREN, ramWEN});
        end
        checks++;
        if ({iload, dload, ramaddr, ramstore} !== '0) begin
            errors++;
            $display("FAIL reset_data: got iload=%h dload=%h addr=%h store=%h want all 0", iload, dload, ramaddr, ramstore);
        end
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        next_cycle();
        checks++;
        if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_idle: got %b want 1100", {iwait, dwait, ramREN, ramWEN});
        end
        exp_iload = '0;
        exp_dload = '0;
    endtask

    task automatic test_instr_read();
        logic [W-1:0] want_il;
        iREN = 1'b1; iaddr = 32'h40;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            ramready = (c == 3);
            ramload  = (c == 3) ? 32'hDEADBEEF : 32'h0;
            if (c == 4) iREN = 1'b0;
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {(c <= 3), 1'b0, (c != 4), 1'b1}) begin
                errors++;
                $display("FAIL ird_ctrl c=%0d: got ren,wen,iw,dw=%b", c, {ramREN, ramWEN, iwait, dwait});
            end
            if (c <= 3) begin
                checks++;
                if (ramaddr !== 32'h40) begin
                    errors++;
                    $display("FAIL ird_addr c=%0d: got %h want 00000040", c, ramaddr);
                end
            end
            want_il = (c >= 4) ? 32'hDEADBEEF : exp_iload;
            checks++;
            if (iload !== want_il) begin
                errors++;
                $display("FAIL ird_iload c=%0d: got %h want %h", c, iload, want_il);
            end
        end
        exp_iload = 32'hDEADBEEF;
    endtask

    task automatic test_data_priority();
        logic [W-1:0] want_il;
        dWEN = 1'b1; dREN = 1'b0; daddr = 32'h80; dstore = 32'h1234;
        iREN = 1'b1; iaddr = 32'h44;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            ramready = (c == 1) || (c == 4);
            ramload  = (c == 1) ? 32'hBADBAD00 : ((c == 4) ? 32'hCAFEF00D : 32'h0);
            if (c == 3) dWEN = 1'b0;
            if (c == 6) iREN = 1'b0;
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {(c == 4), (c == 1), (c != 5), (c != 2)}) begin
                errors++;
                $display("FAIL prio_ctrl c=%0d: got ren,wen,iw,dw=%b", c, {ramREN, ramWEN, iwait, dwait});
            end
            if (c == 1) begin
                checks++;
                if ({ramaddr, ramstore} !== {32'h80, 32'h1234}) begin
                    errors++;
                    $display("FAIL prio_dwr c=%0d: got addr=%h store=%h want 00000080 00001234", c, ramaddr, ramstore);
                end
            end
            if (c == 4) begin
                checks++;
                if (ramaddr !== 32'h44) begin
                    errors++;
                    $display("FAIL prio_iaddr c=%0d: got %h want 00000044", c, ramaddr);
                end
            end
            want_il = (c >= 5) ? 32'hCAFEF00D : exp_iload;
            checks++;
            if ({iload, dload} !== {want_il, exp_dload}) begin
                errors++;
                $display("FAIL prio_loads c=%0d: got iload=%h dload=%h want %h %h", c, iload, dload, want_il, exp_dload);
            end
        end
        exp_iload = 32'hCAFEF00D;
    endtask

    task automatic test_both_ops();
        logic [W-1:0] want_dl;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h90;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            ramready = (c == 1) || (c == 5);
            ramload  = (c == 1) ? 32'h11112222 : ((c == 5) ? 32'hBAD0BAD0 : 32'h0);
            if (c == 2) begin dREN = 1'b1; dWEN = 1'b1; daddr = 32'h94; dstore = 32'h55; end
            if (c == 6) begin dREN = 1'b0; dWEN = 1'b0; end
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {(c == 1), (c == 4 || c == 5), 1'b1, !(c == 2 || c == 6)}) begin
                errors++;
                $display("FAIL both_ctrl c=%0d: got ren,wen,iw,dw=%b", c, {ramREN, ramWEN, iwait, dwait});
            end
            if (c == 1) begin
                checks++;
                if (ramaddr !== 32'h90) begin
                    errors++;
                    $display("FAIL both_raddr c=%0d: got %h want 00000090", c, ramaddr);
                end
            end
            if (c == 4 || c == 5) begin
                checks++;
                if ({ramaddr, ramstore} !== {32'h94, 32'h55}) begin
                    errors++;
                    $display("FAIL both_waddr c=%0d: got addr=%h store=%h want 00000094 00000055", c, ramaddr, ramstore);
                end
            end
            want_dl = (c >= 2) ? 32'h11112222 : exp_dload;
            checks++;
            if (dload !== want_dl) begin
                errors++;
                $display("FAIL both_dload c=%0d: got %h want %h", c, dload, want_dl);
            end
        end
        exp_dload = 32'h11112222;
    endtask

    task automatic test_reset_midflight();
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'hA0;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            ramready = (c == 3);
            ramload  = (c == 3) ? 32'h777 : 32'h0;
            RST      = (c == 1);
            if (c == 1) dREN = 1'b0;
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {(c == 1), 1'b0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL rstmid_ctrl c=%0d: got ren,wen,iw,dw=%b", c, {ramREN, ramWEN, iwait, dwait});
            end
            if (c >= 2) begin
                checks++;
                if ({iload, dload, ramaddr} !== '0) begin
                    errors++;
                    $display("FAIL rstmid_clr c=%0d: got iload=%h dload=%h addr=%h want 0", c, iload, dload, ramaddr);
                end
            end
        end
        exp_iload = '0;
        exp_dload = '0;
    endtask

    task automatic test_starve();
        bit           is_i;
        int           k, ph;
        logic [W-1:0] rd;
        rd = '0;
        dREN = 1'b1; dWEN = 1'b0; daddr = 32'h100;
        iREN = 1'b1; iaddr = 32'h200;
        for (int c = 1; c <= 30; c++) begin
            next_cycle();
            k    = (c - 1) / 3;
            ph   = (c - 1) % 3;
            is_i = GUARD && (k % 5 == 4);
            ramready = (ph == 0);
            ramload  = 32'h5A000000 + c;
            if (c == 30) begin dREN = 1'b0; iREN = 1'b0; end
            if (ph == 0) begin
                rd = ramload;
                checks++;
                if ({ramREN, ramWEN, ramaddr} !== {1'b1, 1'b0, (is_i ? 32'h200 : 32'h100)}) begin
                    errors++;
                    $display("FAIL starve_grant k=%0d: got ren=%b wen=%b addr=%h want instr=%0d", k, ramREN, ramWEN, ramaddr, is_i);
                end
            end else if (ph == 1) begin
                if (is_i) exp_iload = rd; else exp_dload = rd;
                checks++;
                if ({iwait, dwait, iload, dload} !== {!is_i, is_i, exp_iload, exp_dload}) begin
                    errors++;
                    $display("FAIL starve_done k=%0d: got iw=%b dw=%b iload=%h dload=%h want %b %b %h %h",
                             k, iwait, dwait, iload, dload, !is_i, is_i, exp_iload, exp_dload);
                end
            end else begin
                checks++;
                if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
                    errors++;
                    $display("FAIL starve_idle k=%0d: got %b want 0011", k, {ramREN, ramWEN, iwait, dwait});
                end
            end
        end
    endtask

    // Model: grant at edge g, strobes in cycles g+1..g+1+lat, wait low in g+2+lat, free from g+3+lat.
    task automatic test_random();
        int unsigned  cnt;
        bit           busy, kind_i, wr, in_win, done_c, i_act, d_act, d_r, d_w, ifirst, newg;
        int           g, lat, op;
        logic [W-1:0] a, st, rd, ia, da, ds;
        cnt = 0; busy = 0; kind_i = 0; wr = 0; i_act = 0; d_act = 0; d_r = 0; d_w = 0;
        g = 0; lat = 0; a = '0; st = '0; rd = '0; ia = '0; da = '0; ds = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) next_cycle();
            in_win = busy && (c >= g + 1) && (c <= g + 1 + lat);
            done_c = busy && (c == g + 2 + lat);
            if (done_c && !wr) begin
                if (kind_i) exp_iload = rd; else exp_dload = rd;
            end
            checks++;
            if ({ramREN, ramWEN, iwait, dwait} !== {in_win && !wr, in_win && wr, !(done_c && kind_i), !(done_c && !kind_i)}) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d: got ren,wen,iw,dw=%b want %b", c, {ramREN, ramWEN, iwait, dwait},
                         {in_win && !wr, in_win && wr, !(done_c && kind_i), !(done_c && !kind_i)});
            end
            if (in_win) begin
                checks++;
                if (ramaddr !== a || (wr && ramstore !== st)) begin
                    errors++;
                    $display("FAIL rnd_addr c=%0d: got addr=%h store=%h want %h %h", c, ramaddr, ramstore, a, st);
                end
            end
            checks++;
            if ({iload, dload} !== {exp_iload, exp_dload}) begin
                errors++;
                $display("FAIL rnd_loads c=%0d: got iload=%h dload=%h want %h %h", c, iload, dload, exp_iload, exp_dload);
            end
            ramload = $urandom;
            if (in_win && c == g + 1 + lat) begin
                ramready = 1'b1;
                if (wr) begin
                    mem[a[5:2]] = st;
                end else begin
                    ramload = mem[a[5:2]];
                    rd      = ramload;
                end
            end else if (in_win) begin
                ramready = 1'b0;
            end else begin
                ramready = ($urandom_range(0, 7) == 0);
            end
            if (done_c) begin
                busy = 0;
                if (kind_i) i_act = 0; else d_act = 0;
            end
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1; ia = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1; da = $urandom; ds = $urandom;
                op = $urandom_range(0, 2);
                d_r = (op != 1); d_w = (op != 0);
            end
            iREN   = i_act;
            iaddr  = i_act ? ia : $urandom;
            dREN   = d_act && d_r;
            dWEN   = d_act && d_w;
            daddr  = d_act ? da : $urandom;
            dstore = d_act ? ds : $urandom;
            if (!busy && !done_c) begin
                newg   = 0;
                ifirst = GUARD && iREN && (cnt == LIMIT);
                if (ifirst || (!(dREN || dWEN) && iREN)) begin
                    kind_i = 1; wr = 0; a = iaddr; cnt = 0; newg = 1;
                end else if (dREN || dWEN) begin
                    kind_i = 0; wr = dWEN; a = daddr; st = dstore; newg = 1;
                    if (iREN) cnt++;
                end
                if (newg) begin
                    busy = 1; g = c; lat = $urandom_range(0, 3);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        test_reset();
        test_instr_read();
        test_data_priority();
        test_both_ops();
        test_reset_midflight();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
